// File: rtl/macro_celda_pkg.sv
// Shared constants, FSM state types and the byte-strobe merge helper
// for the macro_celda AXI4-Lite register bank.
package macro_celda_pkg;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  localparam int REG_CTRL   = 0;
  localparam int REG_ARG0   = 1;
  localparam int REG_ARG1   = 2;
  localparam int REG_STATUS = 3;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  // Byte i of the result comes from new_val where strb[i] is set, else from old_val.
  function automatic logic [31:0] merge_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/macro_celda_axil_regs.sv
// AXI4-Lite slave holding NUM_REGS 32-bit control registers for the macro_celda core,
// with a one-cycle per-register write pulse.
module macro_celda_axil_regs
  import macro_celda_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 4
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [ADDR_WIDTH-1:0]    S_AXI_AWADDR,
  input  logic [2:0]               S_AXI_AWPROT,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]    S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]  S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]    S_AXI_ARADDR,
  input  logic [2:0]               S_AXI_ARPROT,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]    S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0]   reg_q,
  output logic [NUM_REGS-1:0]      reg_wr_pulse
);

  localparam int IDX_W = ADDR_WIDTH - 2;

  logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
  w_state_t                w_state, w_state_nxt;
  r_state_t                r_state, r_state_nxt;
  logic                    aw_held, w_held;
  logic [IDX_W-1:0]        aw_idx;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs, do_write;

  // Protection bits and the byte offset within a word carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign aw_hs    = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs     = S_AXI_WVALID && S_AXI_WREADY;
  assign b_hs     = S_AXI_BVALID && S_AXI_BREADY;
  assign ar_hs    = S_AXI_ARVALID && S_AXI_ARREADY;
  assign r_hs     = S_AXI_RVALID && S_AXI_RREADY;
  assign do_write = (w_state == W_IDLE) && aw_held && w_held;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) w_state <= W_IDLE;
    else        w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (do_write) w_state_nxt = W_RESP;
      W_RESP:  if (S_AXI_BREADY) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_AWREADY = (w_state == W_IDLE) && !aw_held;
    S_AXI_WREADY  = (w_state == W_IDLE) && !w_held;
    S_AXI_BVALID  = (w_state == W_RESP);
    S_AXI_BRESP   = AXI_RESP_OKAY;
  end

  // Address and data halves are captured independently; the pair is consumed
  // one edge after both are held, and released once the response is taken.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_idx  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else if (b_hs) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx  <= S_AXI_AWADDR[ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      if (do_write) begin
        regs[aw_idx] <= merge_strb(regs[aw_idx], w_data, w_strb);
        reg_wr_pulse <= NUM_REGS'(1) << aw_idx;
      end
    end
  end

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_q[32*i +: 32] = regs[i];
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_state <= R_IDLE;
    else        r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
      R_DATA:  if (r_hs) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    S_AXI_ARREADY = (r_state == R_IDLE);
    S_AXI_RVALID  = (r_state == R_DATA);
    S_AXI_RRESP   = AXI_RESP_OKAY;
    S_AXI_RDATA   = rdata_q;
  end

  // Sampled before this edge's register update, so a colliding write is not visible.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)     rdata_q <= '0;
    else if (ar_hs) rdata_q <= regs[S_AXI_ARADDR[ADDR_WIDTH-1:2]];
  end

endmodule

// File: tb/tb_macro_celda_axil_regs.sv
// Self-checking bench for macro_celda_axil_regs: directed scenarios plus randomized
// overlapping traffic, compared every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_macro_celda_axil_regs;

  localparam int ADDR_WIDTH = 4;
  localparam int NUM_REGS   = 4;

  logic                    ACLK = 1'b0;
  logic                    ARESET = 1'b1;
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR = '0;
  logic [2:0]              S_AXI_AWPROT = '0;
  logic                    S_AXI_AWVALID = 1'b0;
  logic                    S_AXI_AWREADY;
  logic [31:0]             S_AXI_WDATA = '0;
  logic [3:0]              S_AXI_WSTRB = '0;
  logic                    S_AXI_WVALID = 1'b0;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY = 1'b0;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR = '0;
  logic [2:0]              S_AXI_ARPROT = '0;
  logic                    S_AXI_ARVALID = 1'b0;
  logic                    S_AXI_ARREADY;
  logic [31:0]             S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY = 1'b0;
  logic [NUM_REGS*32-1:0]  reg_q;
  logic [NUM_REGS-1:0]     reg_wr_pulse;

  int errors = 0;
  int checks = 0;
  bit model_check_en = 1'b0;
  logic [31:0] rd;

  always #5 ACLK = ~ACLK;

  macro_celda_axil_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(ADDR_WIDTH), .NUM_REGS(NUM_REGS)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
  );

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: pending address index (-1 = none), pending data, one outstanding
  // response, and a register array whose reads see the value before a same-edge write.
  logic [31:0] m_regs [NUM_REGS];
  int          m_aw_idx;
  bit          m_w_have;
  logic [31:0] m_w_data;
  logic [3:0]  m_w_strb;
  bit          m_b_pending;
  int          m_pulse_idx;
  bit          m_r_pending;
  logic [31:0] m_rdata;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0] strb);
    logic [31:0] mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) m_regs[i] <= '0;
      m_aw_idx    <= -1;
      m_w_have    <= 1'b0;
      m_w_data    <= '0;
      m_w_strb    <= '0;
      m_b_pending <= 1'b0;
      m_pulse_idx <= -1;
      m_r_pending <= 1'b0;
      m_rdata     <= '0;
    end else begin
      if (m_r_pending) begin
        if (S_AXI_RREADY) m_r_pending <= 1'b0;
      end else if (S_AXI_ARVALID) begin
        m_rdata     <= m_regs[int'(S_AXI_ARADDR) / 4];
        m_r_pending <= 1'b1;
      end
      m_pulse_idx <= -1;
      if (m_b_pending) begin
        if (S_AXI_BREADY) begin
          m_b_pending <= 1'b0;
          m_aw_idx    <= -1;
          m_w_have    <= 1'b0;
        end
      end else if (m_aw_idx >= 0 && m_w_have) begin
        m_regs[m_aw_idx] <= byte_merge(m_regs[m_aw_idx], m_w_data, m_w_strb);
        m_pulse_idx      <= m_aw_idx;
        m_b_pending      <= 1'b1;
      end else begin
        if (m_aw_idx < 0 && S_AXI_AWVALID) m_aw_idx <= int'(S_AXI_AWADDR) / 4;
        if (!m_w_have && S_AXI_WVALID) begin
          m_w_have <= 1'b1;
          m_w_data <= S_AXI_WDATA;
          m_w_strb <= S_AXI_WSTRB;
        end
      end
    end
  end

  always @(negedge ACLK) begin
    if (model_check_en && !ARESET) begin
      logic [127:0] exp_q;
      exp_q = '0;
      for (int i = 0; i < NUM_REGS; i++) exp_q[32*i +: 32] = m_regs[i];
      checkOutput("awready", 128'(S_AXI_AWREADY), 128'(!m_b_pending && m_aw_idx < 0));
      checkOutput("wready",  128'(S_AXI_WREADY),  128'(!m_b_pending && !m_w_have));
      checkOutput("bvalid",  128'(S_AXI_BVALID),  128'(m_b_pending));
      checkOutput("arready", 128'(S_AXI_ARREADY), 128'(!m_r_pending));
      checkOutput("rvalid",  128'(S_AXI_RVALID),  128'(m_r_pending));
      checkOutput("reg_q",   reg_q, exp_q);
      checkOutput("reg_wr_pulse", 128'(reg_wr_pulse),
                  (m_pulse_idx < 0) ? 128'(0) : (128'(1) << m_pulse_idx));
      if (m_r_pending) checkOutput("rdata", 128'(S_AXI_RDATA), 128'(m_rdata));
    end
  end

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_delay,
                           input int w_delay, input int b_delay);
    bit aw_done = 1'b0, w_done = 1'b0, b_done = 1'b0;
    int both_at = -1;
    int pulses = 0;
    S_AXI_AWADDR = addr;
    S_AXI_WDATA  = data;
    S_AXI_WSTRB  = strb;
    for (int cyc = 0; cyc < 60 && !b_done; cyc++) begin
      S_AXI_AWVALID = !aw_done && cyc >= aw_delay;
      S_AXI_WVALID  = !w_done && cyc >= w_delay;
      S_AXI_BREADY  = both_at >= 0 && cyc - both_at >= b_delay;
      @(negedge ACLK);
      if (reg_wr_pulse != '0) begin
        pulses++;
        checkOutput("wr_pulse_bit", 128'(reg_wr_pulse), 128'(4'b0001 << addr[3:2]));
      end
      if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1'b1;
      if (S_AXI_WVALID && S_AXI_WREADY) w_done = 1'b1;
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        b_done = 1'b1;
        checkOutput("bresp", 128'(S_AXI_BRESP), 128'(0));
      end
      if (aw_done && w_done && both_at < 0) both_at = cyc + 1;
      @(posedge ACLK);
      #1;
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    S_AXI_BREADY  = 1'b0;
    checkOutput("write_done", 128'(b_done), 128'(1));
    checkOutput("wr_pulse_count", 128'(pulses), 128'(1));
  endtask

  task automatic axi_read(input logic [3:0] addr, input int ar_delay,
                          input int r_delay, output logic [31:0] data);
    bit ar_done = 1'b0, r_done = 1'b0, seen = 1'b0;
    int ar_at = -1;
    logic [31:0] first;
    first = '0;
    data  = '0;
    S_AXI_ARADDR = addr;
    for (int cyc = 0; cyc < 60 && !r_done; cyc++) begin
      S_AXI_ARVALID = !ar_done && cyc >= ar_delay;
      S_AXI_RREADY  = ar_at >= 0 && cyc - ar_at >= r_delay;
      @(negedge ACLK);
      if (S_AXI_RVALID) begin
        if (!seen) begin
          first = S_AXI_RDATA;
          seen  = 1'b1;
        end else begin
          checkOutput("rdata_stable", 128'(S_AXI_RDATA), 128'(first));
        end
      end
      if (S_AXI_ARVALID && S_AXI_ARREADY) begin
        ar_done = 1'b1;
        ar_at   = cyc + 1;
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        r_done = 1'b1;
        data   = S_AXI_RDATA;
        checkOutput("rresp", 128'(S_AXI_RRESP), 128'(0));
      end
      @(posedge ACLK);
      #1;
    end
    S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY  = 1'b0;
    checkOutput("read_done", 128'(r_done), 128'(1));
  endtask

  task automatic wait_bvalid(input string name);
    bit seen = 1'b0;
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      @(negedge ACLK);
      seen = S_AXI_BVALID;
      @(posedge ACLK);
      #1;
    end
    checkOutput(name, 128'(seen), 128'(1));
  endtask

  // Overlapping random write and read per iteration; the per-cycle model does the checking.
  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      logic [3:0]  waddr, raddr, strb;
      logic [31:0] data, rdv;
      int awd, wd, bd, ard, rdd;
      waddr = 4'($urandom_range(0, 15));
      raddr = 4'($urandom_range(0, 15));
      strb  = 4'($urandom_range(0, 15));
      data  = $urandom;
      awd = $urandom_range(0, 3);
      wd  = $urandom_range(0, 3);
      bd  = $urandom_range(0, 3);
      ard = $urandom_range(0, 4);
      rdd = $urandom_range(0, 3);
      fork
        axi_write(waddr, data, strb, awd, wd, bd);
        axi_read(raddr, ard, rdd, rdv);
      join
    end
  endtask

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100;
    checkOutput("rst_awready", 128'(S_AXI_AWREADY), 128'(1));
    checkOutput("rst_wready",  128'(S_AXI_WREADY),  128'(1));
    checkOutput("rst_arready", 128'(S_AXI_ARREADY), 128'(1));
    checkOutput("rst_bvalid",  128'(S_AXI_BVALID),  128'(0));
    checkOutput("rst_rvalid",  128'(S_AXI_RVALID),  128'(0));
    checkOutput("rst_rdata",   128'(S_AXI_RDATA),   128'(0));
    checkOutput("rst_reg_q",   reg_q,               128'(0));
    checkOutput("rst_pulse",   128'(reg_wr_pulse),  128'(0));
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    model_check_en = 1'b1;

    $display("[TB] sequential writes and reads");
    for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), 0, 0, rd);
      checkOutput("seq_read", 128'(rd), 128'(i + 1));
    end

    $display("[TB] W before AW");
    axi_write(4'h8, 32'hDEADBEEF, 4'hF, 3, 0, 0);
    axi_read(4'h8, 0, 0, rd);
    checkOutput("w_first_read", 128'(rd), 128'h DEADBEEF);

    $display("[TB] byte strobes");
    axi_write(4'h4, 32'h11223344, 4'hF, 0, 0, 0);
    axi_write(4'h4, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
    axi_read(4'h4, 0, 0, rd);
    checkOutput("strb_read", 128'(rd), 128'h11BB33DD);
    axi_write(4'h5, 32'hFFFFFFFF, 4'h0, 1, 0, 1);
    axi_read(4'h6, 0, 0, rd);
    checkOutput("strb_zero_read", 128'(rd), 128'h11BB33DD);

    $display("[TB] write response backpressure");
    S_AXI_AWADDR  = 4'h0;
    S_AXI_WDATA   = 32'hA5A50001;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    @(posedge ACLK);
    #1;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    wait_bvalid("bp_bvalid_rise");
    S_AXI_AWADDR  = 4'h8;
    S_AXI_WDATA   = 32'hA5A50002;
    S_AXI_AWVALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      checkOutput("bp_bvalid_held", 128'(S_AXI_BVALID), 128'(1));
      checkOutput("bp_aw_blocked", 128'(S_AXI_AWREADY), 128'(0));
      @(posedge ACLK);
      #1;
    end
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK);
    #1;
    S_AXI_BREADY = 1'b0;
    axi_write(4'h8, 32'hA5A50002, 4'hF, 0, 0, 0);
    axi_read(4'h0, 0, 0, rd);
    checkOutput("bp_first_read", 128'(rd), 128'hA5A50001);
    axi_read(4'h8, 0, 5, rd);
    checkOutput("bp_second_read", 128'(rd), 128'hA5A50002);

    $display("[TB] same-edge write and read");
    fork
      axi_write(4'hC, 32'h55, 4'hF, 0, 0, 0);
      axi_read(4'hC, 1, 0, rd);
    join
    checkOutput("collide_old", 128'(rd), 128'h4);
    axi_read(4'hC, 0, 0, rd);
    checkOutput("collide_new", 128'(rd), 128'h55);

    $display("[TB] randomized traffic");
    applyStimulus(40);

    $display("[TB] reset with response pending");
    S_AXI_AWADDR  = 4'h4;
    S_AXI_WDATA   = 32'h00000777;
    S_AXI_WSTRB   = 4'hF;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WVALID  = 1'b1;
    @(posedge ACLK);
    #1;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    wait_bvalid("mid_bvalid_rise");
    #2;
    ARESET = 1'b1;
    #1;
    checkOutput("mid_rst_bvalid",  128'(S_AXI_BVALID),  128'(0));
    checkOutput("mid_rst_awready", 128'(S_AXI_AWREADY), 128'(1));
    checkOutput("mid_rst_reg_q",   reg_q,               128'(0));
    repeat (2) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(i * 4), 0, 0, rd);
      checkOutput("post_rst_read", 128'(rd), 128'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
